// File: rtl/pe_layer_seq_pkg.sv
// ============================================================================
// Module   : pe_layer_seq_pkg
// Purpose  : Shared state encoding, default sizes and channel-width helper
//            for the PE layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_layer_seq_pkg;

    localparam int c_NUM_CH_DEFAULT = 3;
    localparam int c_K_W_DEFAULT    = 8;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_LOAD_IN  = 3'd2,
        ST_LOAD_FLT = 3'd3,
        ST_PPU_WAIT = 3'd4,
        ST_SWAP     = 3'd5,
        ST_DONE     = 3'd6
    } pe_seq_state_e;

endpackage

`default_nettype wire

// File: rtl/pe_layer_seq_ch_pick.sv
// ============================================================================
// Module   : ch_pick
// Purpose  : Lowest-set-bit priority encoder over the remaining channel mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ch_pick
    import pe_layer_seq_pkg::*;
#(
    parameter int N = c_NUM_CH_DEFAULT,
    parameter int W = ch_width(N)
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_layer_seq.sv
// ============================================================================
// Module   : pe_layer_seq
// Purpose  : Sequences input load, per-group filter load and PPU write-back
//            over the enabled channels of one layer, then swaps the bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_layer_seq
    import pe_layer_seq_pkg::*;
#(
    parameter  int NUM_CH = c_NUM_CH_DEFAULT,
    parameter  int K_W    = c_K_W_DEFAULT,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] valid_channel,
    input  logic [K_W-1:0]    k_groups,
    input  logic              in_finish,
    input  logic              filter_finish,
    input  logic              ppu_finish,
    output logic              req_input,
    output logic              req_filter,
    output logic [CH_W-1:0]   ch_sel,
    output logic [K_W-1:0]    kg_cnt,
    output logic              bank_sel,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err
);

    pe_seq_state_e     r_state;
    pe_seq_state_e     w_state_nxt;
    logic [NUM_CH-1:0] r_rem_mask;
    logic [K_W-1:0]    r_kg_max;
    logic [K_W-1:0]    r_kg_cnt;
    logic [CH_W-1:0]   r_ch_sel;
    logic              r_bank_sel;
    logic              r_mask_nz;
    logic              r_err;
    logic              r_done;

    logic [CH_W-1:0]   w_pick_idx;
    logic              w_pick_any;
    logic              w_start_acc;
    logic              w_scan_pick;
    logic              w_kg_inc;
    logic              w_swap;
    logic              w_stray;

    ch_pick #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_ch_pick (
        .mask (r_rem_mask),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_scan_pick = 1'b0;
        w_kg_inc    = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_pick_any) begin
                    w_scan_pick = 1'b1;
                    w_state_nxt = ST_LOAD_IN;
                end else begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_LOAD_IN: begin
                if (in_finish) begin
                    w_state_nxt = ST_LOAD_FLT;
                end
            end
            ST_LOAD_FLT: begin
                if (filter_finish) begin
                    w_state_nxt = ST_PPU_WAIT;
                end
            end
            ST_PPU_WAIT: begin
                if (ppu_finish) begin
                    if (r_kg_cnt == r_kg_max - K_W'(1)) begin
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_kg_inc    = 1'b1;
                        w_state_nxt = ST_LOAD_FLT;
                    end
                end
            end
            ST_SWAP: begin
                w_swap      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A finish strobe is only legal in the one state that consumes it.
    assign w_stray = (in_finish     && (r_state != ST_LOAD_IN))
                   | (filter_finish && (r_state != ST_LOAD_FLT))
                   | (ppu_finish    && (r_state != ST_PPU_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_mask <= '0;
            r_kg_max   <= '0;
            r_kg_cnt   <= '0;
            r_ch_sel   <= '0;
            r_bank_sel <= 1'b0;
            r_mask_nz  <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
            r_err  <= (w_start_acc ? 1'b0 : r_err) | w_stray;
            if (w_start_acc) begin
                r_rem_mask <= valid_channel;
                r_kg_max   <= (k_groups == '0) ? K_W'(1) : k_groups;
                r_mask_nz  <= |valid_channel;
            end
            if (w_scan_pick) begin
                r_ch_sel   <= w_pick_idx;
                r_rem_mask <= r_rem_mask & (r_rem_mask - NUM_CH'(1));
                r_kg_cnt   <= '0;
            end
            if (w_kg_inc) begin
                r_kg_cnt <= r_kg_cnt + K_W'(1);
            end
            if (w_swap && r_mask_nz) begin
                r_bank_sel <= ~r_bank_sel;
            end
        end
    end

    assign req_input  = (r_state == ST_LOAD_IN);
    assign req_filter = (r_state == ST_LOAD_FLT);
    assign busy       = (r_state != ST_IDLE);
    assign state      = r_state;
    assign ch_sel     = r_ch_sel;
    assign kg_cnt     = r_kg_cnt;
    assign bank_sel   = r_bank_sel;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pe_layer_seq.sv
// ============================================================================
// Module   : tb_pe_layer_seq
// Purpose  : Scoreboard bench for pe_layer_seq against a per-layer
//            transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_layer_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] valid_channel;
    logic [7:0] k_groups;
    logic       in_finish;
    logic       filter_finish;
    logic       ppu_finish;
    logic       req_input;
    logic       req_filter;
    logic [1:0] ch_sel;
    logic [7:0] kg_cnt;
    logic       bank_sel;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic       err;

    pe_layer_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .valid_channel (valid_channel),
        .k_groups      (k_groups),
        .in_finish     (in_finish),
        .filter_finish (filter_finish),
        .ppu_finish    (ppu_finish),
        .req_input     (req_input),
        .req_filter    (req_filter),
        .ch_sel        (ch_sel),
        .kg_cnt        (kg_cnt),
        .bank_sel      (bank_sel),
        .state         (state),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = input request, 1 = filter request, 2 = layer done
    typedef struct {
        int kind;
        int ch;
        int kg;
        int bank;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  model_bank = 0;

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    // Expected transactions for one layer: channels ascending, each one input
    // load followed by max(k,1) filter groups, then done with the new bank.
    function automatic void push_layer(logic [2:0] mask, int kg);
        int ngrp;
        ev_t e;
        ngrp = (kg == 0) ? 1 : kg;
        for (int c = 0; c < 3; c++) begin
            if (mask[c]) begin
                e = '{kind: 0, ch: c, kg: 0, bank: 0};
                exp_q.push_back(e);
                for (int g = 0; g < ngrp; g++) begin
                    e = '{kind: 1, ch: c, kg: g, bank: 0};
                    exp_q.push_back(e);
                end
            end
        end
        if (mask != 3'b000) model_bank = 1 - model_bank;
        e = '{kind: 2, ch: 0, kg: 0, bank: model_bank};
        exp_q.push_back(e);
    endfunction

    function automatic void got_ev(int kind, int ch, int kg, int bank);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d ch %0d kg %0d bank %0d, expected none",
                     kind, ch, kg, bank);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_ch", ch, e.ch);
            chk("ev_kg", kg, e.kg);
            chk("ev_bank", bank, e.bank);
        end
    endfunction

    // Monitor: turns DUT outputs into transactions and checks them in order.
    initial begin
        int prev;
        prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (state == 3'd2 && prev != 2) got_ev(0, int'(ch_sel), 0, 0);
                if (state == 3'd3 && prev != 3) got_ev(1, int'(ch_sel), int'(kg_cnt), 0);
                if (done) got_ev(2, 0, 0, int'(bank_sel));
            end
            prev = int'(state);
        end
    end

    task automatic do_start(input logic [2:0] mask, input int kg);
        @(negedge clk);
        start         = 1'b1;
        valid_channel = mask;
        k_groups      = 8'(kg);
        push_layer(mask, kg);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    // Answers requests with random latency and fires ignored starts while busy.
    task automatic drive(input int stop_at_ppu, input int fast, output int hit);
        hit = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            in_finish     = 1'b0;
            filter_finish = 1'b0;
            ppu_finish    = 1'b0;
            start         = 1'b0;
            if ((stop_at_ppu != 0 && state == 3'd4) || done) begin
                hit = 1;
                return;
            end
            if (req_input  && (fast != 0 || $urandom % 2 == 0)) in_finish     = 1'b1;
            if (req_filter && (fast != 0 || $urandom % 2 == 0)) filter_finish = 1'b1;
            if (state == 3'd4 && (fast != 0 || $urandom % 2 == 0)) ppu_finish = 1'b1;
            if (busy && $urandom % 6 == 0) begin
                start         = 1'b1;
                valid_channel = 3'($urandom);
                k_groups      = 8'($urandom);
            end
        end
    endtask

    task automatic finish_layer(input int fast);
        int hit;
        drive(0, fast, hit);
        chk("layer_complete", hit, 1);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_after_done", int'(state), 0);
        chk("bank_after_done", int'(bank_sel), model_bank);
    endtask

    task automatic check_reset_outputs();
        chk("rst_state", int'(state), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        chk("rst_kg_cnt", int'(kg_cnt), 0);
        chk("rst_bank", int'(bank_sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_req_in", int'(req_input), 0);
        chk("rst_req_flt", int'(req_filter), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        int seen;
        rst = 1'b1;
        start = 1'b0;
        valid_channel = 3'b111;
        k_groups = 8'd2;
        in_finish = 1'b0;
        filter_finish = 1'b0;
        ppu_finish = 1'b0;
        // start held during reset must not launch a layer
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;

        // full mask, two groups, immediate finishes
        do_start(3'b111, 2);
        finish_layer(1);

        // sparse mask, middle channel skipped
        do_start(3'b101, 1);
        finish_layer(0);

        // empty mask walks SCAN -> SWAP -> DONE with no bank toggle
        do_start(3'b000, 3);
        chk("empty_scan", int'(state), 1);
        @(negedge clk);
        chk("empty_swap", int'(state), 5);
        @(negedge clk);
        chk("empty_done_state", int'(state), 6);
        chk("empty_done_pulse", int'(done), 1);
        @(negedge clk);
        chk("empty_idle", int'(state), 0);
        chk("empty_done_low", int'(done), 0);
        chk("empty_bank", int'(bank_sel), model_bank);

        // zero groups behaves as one group per channel
        do_start(3'b011, 0);
        finish_layer(0);

        // stray ppu_finish while loading input: sticky err, state held
        do_start(3'b001, 1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (state == 3'd2) seen = 1;
        end
        chk("reach_load_in", seen, 1);
        ppu_finish = 1'b1;
        @(negedge clk);
        ppu_finish = 1'b0;
        chk("stray_err", int'(err), 1);
        chk("stray_state_held", int'(state), 2);
        finish_layer(0);
        chk("err_sticky", int'(err), 1);
        do_start(3'b010, 2);
        chk("err_cleared", int'(err), 0);
        finish_layer(0);

        // reset during PPU_WAIT aborts the layer silently
        do_start(3'b111, 3);
        drive(1, 0, hit);
        chk("reach_ppu_wait", hit, 1);
        rst = 1'b1;
        exp_q.delete();
        model_bank = 0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_after_abort", int'(busy), 0);

        do_start(3'b110, 2);
        finish_layer(0);

        // random layers
        for (int n = 0; n < 12; n++) begin
            do_start(3'($urandom), int'($urandom_range(0, 4)));
            finish_layer(int'($urandom % 2));
            chk("rand_err_clear", int'(err), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
